// File: rtl/aes_stream_engine_if.sv
// Block stream interface for aes_stream_engine: input block handshake,
// result handshake and the busy indication.
interface aes_stream_engine_if;
  logic         i_Valid;
  logic         o_Ready;
  logic [127:0] i_Data;
  logic         o_Valid;
  logic         i_Ready;
  logic [127:0] o_Data;
  logic         o_Busy;

  // Engine side
  modport slave (
    input  i_Valid, i_Data, i_Ready,
    output o_Ready, o_Valid, o_Data, o_Busy
  );

  // Source/sink side
  modport master (
    output i_Valid, i_Data, i_Ready,
    input  o_Ready, o_Valid, o_Data, o_Busy
  );
endinterface

// File: rtl/aes_stream_engine.sv
// Iterative AES-128 encryption engine, one round per clock, with round keys
// derived on the fly. MODE 0 = ECB, MODE 1 = CTR (low CTR_WIDTH counter bits
// increment per block without carrying into the upper bits).
module aes_stream_engine #(
  parameter int MODE      = 0,
  parameter int CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [127:0]         i_Key,
  input  logic                 i_Key_Load,
  input  logic [127:0]         i_Ctr,
  input  logic                 i_Ctr_Load,
  aes_stream_engine_if.slave   bus
);

  localparam logic         CTR_MODE = (MODE == 32'sd1);
  // Mask of the counter bits that take part in the per-block increment.
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

  // Byte b of the table sits at bits [8*(255-b)+7 -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;
  typedef logic [0:15][7:0] blk_t;   // element i = byte i, FIPS-197 order

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes followed by ShiftRows: out(row r, col c) = in(row r, col c+r).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    blk_t b;
    blk_t t;
    b = s;
    t[0]  = sbox(b[0]);  t[1]  = sbox(b[5]);  t[2]  = sbox(b[10]); t[3]  = sbox(b[15]);
    t[4]  = sbox(b[4]);  t[5]  = sbox(b[9]);  t[6]  = sbox(b[14]); t[7]  = sbox(b[3]);
    t[8]  = sbox(b[8]);  t[9]  = sbox(b[13]); t[10] = sbox(b[2]);  t[11] = sbox(b[7]);
    t[12] = sbox(b[12]); t[13] = sbox(b[1]);  t[14] = sbox(b[6]);  t[15] = sbox(b[11]);
    return t;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] v;
    v = sub_shift(s);
    if (!last) begin
      v = {mix_col(v[127:96]), mix_col(v[95:64]), mix_col(v[63:32]), mix_col(v[31:0])};
    end else begin
      v = v;
    end
    return v ^ rk;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = rk[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_t       state_r, state_next_s;
  logic [3:0]   rnd_r;
  logic [127:0] key_r, ctr_r, st_r, rk_r, din_r, out_r;
  logic         key_ok_r, valid_r, ready_r, busy_r;

  logic         key_ld_s, ctr_ld_s, accept_s, last_s, key_ok_next_s;
  logic [127:0] key_eff_s, ctr_eff_s, aes_in_s, ctr_inc_s, rk_next_s, round_s;

  // Loads, effective key/counter, accept and the round datapath.
  always_comb begin
    key_ld_s      = i_Key_Load && (state_r == IDLE);
    ctr_ld_s      = i_Ctr_Load && (state_r == IDLE);
    key_eff_s     = key_ld_s ? i_Key : key_r;
    ctr_eff_s     = ctr_ld_s ? i_Ctr : ctr_r;
    accept_s      = bus.i_Valid && ready_r;
    aes_in_s      = CTR_MODE ? ctr_eff_s : bus.i_Data;
    ctr_inc_s     = (ctr_eff_s & ~CTR_MASK) | ((ctr_eff_s + 128'd1) & CTR_MASK);
    key_ok_next_s = key_ok_r || key_ld_s;
    last_s        = (rnd_r == 4'd10);
    rk_next_s     = next_key(rk_r, rcon(rnd_r));
    round_s       = aes_round(st_r, rk_next_s, last_s);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_next_s = ROUND; else state_next_s = IDLE;
      ROUND:   if (last_s) state_next_s = DONE; else state_next_s = ROUND;
      DONE:    if (valid_r && bus.i_Ready) state_next_s = IDLE; else state_next_s = DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // Key/counter registers, AES state, running round key and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r    <= 128'd0;
      key_ok_r <= 1'b0;
      ctr_r    <= 128'd0;
      st_r     <= 128'd0;
      rk_r     <= 128'd0;
      din_r    <= 128'd0;
      out_r    <= 128'd0;
      rnd_r    <= 4'd0;
    end else begin
      key_ok_r <= key_ok_next_s;
      if (key_ld_s) key_r <= i_Key;
      if (CTR_MODE && accept_s) ctr_r <= ctr_inc_s;
      else if (ctr_ld_s)        ctr_r <= i_Ctr;
      if (accept_s) begin
        st_r  <= aes_in_s ^ key_eff_s;
        rk_r  <= key_eff_s;
        din_r <= bus.i_Data;
        rnd_r <= 4'd1;
      end else if (state_r == ROUND) begin
        st_r  <= round_s;
        rk_r  <= rk_next_s;
        rnd_r <= rnd_r + 4'd1;
        if (last_s) out_r <= round_s ^ (CTR_MODE ? din_r : 128'd0);
      end
    end
  end

  // Registered handshake/status outputs, derived from the next state only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      valid_r <= (state_next_s == DONE);
      ready_r <= (state_next_s == IDLE) && key_ok_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  assign bus.o_Valid = valid_r;
  assign bus.o_Ready = ready_r;
  assign bus.o_Busy  = busy_r;
  assign bus.o_Data  = out_r;

endmodule

// File: tb/tb_aes_stream_engine.sv
// Directed bench for aes_stream_engine: one ECB and one CTR instance,
// expected results queued at accept and compared at the output handshake.
module tb_aes_stream_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_stream_engine_if ecb_if ();
  aes_stream_engine_if ctr_if ();

  logic [127:0] ecb_key, ecb_ctr, ctr_key, ctr_ctr;
  logic         ecb_key_ld, ecb_ctr_ld, ctr_key_ld, ctr_ctr_ld;

  aes_stream_engine #(.MODE(0), .CTR_WIDTH(32)) u_ecb (
    .clk(clk), .rst_n(rst_n), .i_Key(ecb_key), .i_Key_Load(ecb_key_ld),
    .i_Ctr(ecb_ctr), .i_Ctr_Load(ecb_ctr_ld), .bus(ecb_if.slave)
  );

  aes_stream_engine #(.MODE(1), .CTR_WIDTH(32)) u_ctr (
    .clk(clk), .rst_n(rst_n), .i_Key(ctr_key), .i_Key_Load(ctr_key_ld),
    .i_Ctr(ctr_ctr), .i_Ctr_Load(ctr_ctr_ld), .bus(ctr_if.slave)
  );

  int           checks = 0;
  int           errors = 0;
  logic [127:0] sb_q[$];
  logic [7:0]   tsb[256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Reference AES-128 built on an S-box derived from GF(2^8) inversion.
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s[16], t[16];
    logic [7:0]   a0, a1, a2, a3, rc;
    logic [31:0]  w, tmp;
    logic [127:0] rk, res;
    rk = key; rc = 8'h01;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      w   = rk[31:0];
      tmp = {tsb[w[23:16]], tsb[w[15:8]], tsb[w[7:0]], tsb[w[31:24]]} ^ {rc, 24'h000000};
      rk[127:96] = rk[127:96] ^ tmp;
      rk[95:64]  = rk[95:64]  ^ rk[127:96];
      rk[63:32]  = rk[63:32]  ^ rk[95:64];
      rk[31:0]   = rk[31:0]   ^ rk[63:32];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = tsb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one block once o_Ready is seen; the following edge accepts it.
  task automatic send(input bit use_ctr, input logic [127:0] data, input logic [127:0] exp);
    int n = 0;
    bit rdy;
    rdy = use_ctr ? ctr_if.o_Ready : ecb_if.o_Ready;
    while (!rdy && n < 30) begin
      step(1); n++;
      rdy = use_ctr ? ctr_if.o_Ready : ecb_if.o_Ready;
    end
    chk("ready_before_send", {127'd0, rdy}, 128'd1);
    if (use_ctr) begin ctr_if.i_Valid = 1'b1; ctr_if.i_Data = data; end
    else begin ecb_if.i_Valid = 1'b1; ecb_if.i_Data = data; end
    sb_q.push_back(exp);
    step(1);
    if (use_ctr) ctr_if.i_Valid = 1'b0; else ecb_if.i_Valid = 1'b0;
  endtask

  // Wait for o_Valid, compare against the scoreboard, then complete the handshake.
  task automatic recv(input bit use_ctr, input string tag, output int lat);
    int n = 0;
    bit v;
    logic [127:0] exp, obs;
    if (use_ctr) ctr_if.i_Ready = 1'b1; else ecb_if.i_Ready = 1'b1;
    v = use_ctr ? ctr_if.o_Valid : ecb_if.o_Valid;
    while (!v && n < 30) begin
      step(1); n++;
      v = use_ctr ? ctr_if.o_Valid : ecb_if.o_Valid;
    end
    lat = n;
    chk({tag, "_valid"}, {127'd0, v}, 128'd1);
    obs = use_ctr ? ctr_if.o_Data : ecb_if.o_Data;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    else exp = 128'bx;
    chk(tag, obs, exp);
    step(1);
    if (use_ctr) ctr_if.i_Ready = 1'b0; else ecb_if.i_Ready = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    bit ok;
    logic [7:0]   inv, xb, ab;
    logic [127:0] d0, k_fips, k_nist, ctr_wrap;

    for (int x = 0; x < 256; x++) begin
      xb = x[7:0]; inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      ab = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      tsb[x] = ab;
    end

    k_fips   = 128'h000102030405060708090a0b0c0d0e0f;
    k_nist   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ctr_wrap = 128'h000000000000000000000000ffffffff;

    rst_n = 1'b0;
    ecb_key = 128'd0; ecb_ctr = 128'd0; ecb_key_ld = 1'b0; ecb_ctr_ld = 1'b0;
    ctr_key = 128'd0; ctr_ctr = 128'd0; ctr_key_ld = 1'b0; ctr_ctr_ld = 1'b0;
    ecb_if.i_Valid = 1'b0; ecb_if.i_Data = 128'd0; ecb_if.i_Ready = 1'b0;
    ctr_if.i_Valid = 1'b0; ctr_if.i_Data = 128'd0; ctr_if.i_Ready = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Reset state
    chk("rst_valid", ecb_if.o_Valid, 128'd0);
    chk("rst_ready", ecb_if.o_Ready, 128'd0);
    chk("rst_busy",  ecb_if.o_Busy,  128'd0);
    chk("rst_data",  ecb_if.o_Data,  128'd0);
    chk("rst_ctr_ready", ctr_if.o_Ready, 128'd0);

    // No key loaded: valid input is ignored for 20 cycles
    ecb_if.i_Valid = 1'b1; ecb_if.i_Data = 128'h00112233445566778899aabbccddeeff;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ecb_if.o_Ready !== 1'b0 || ecb_if.o_Valid !== 1'b0) ok = 1'b0;
    end
    chk("nokey_idle", ok, 128'd1);
    ecb_if.i_Valid = 1'b0;

    // Key load makes the engine ready on the next cycle
    ecb_key = k_fips; ecb_key_ld = 1'b1;
    step(1);
    ecb_key_ld = 1'b0;
    chk("keyload_ready", ecb_if.o_Ready, 128'd1);

    // ECB FIPS-197 vector with latency
    send(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("inflight_busy",  ecb_if.o_Busy,  128'd1);
    chk("inflight_ready", ecb_if.o_Ready, 128'd0);
    recv(1'b0, "ecb_fips", lat);
    chk("ecb_latency", lat, 128'd10);
    chk("post_hs_ready", ecb_if.o_Ready, 128'd1);
    chk("post_hs_valid", ecb_if.o_Valid, 128'd0);

    // Key load coinciding with accept, ROUND-time key pulse, output back-pressure
    ecb_key = k_nist; ecb_key_ld = 1'b1;
    send(1'b0, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
    ecb_key_ld = 1'b0;
    step(1);
    ecb_key = {4{32'hdeadbeef}}; ecb_key_ld = 1'b1;
    step(1);
    ecb_key_ld = 1'b0;
    n = 0;
    while (ecb_if.o_Valid !== 1'b1 && n < 30) begin step(1); n++; end
    chk("bp_valid", ecb_if.o_Valid, 128'd1);
    d0 = ecb_if.o_Data;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (ecb_if.o_Data !== d0 || ecb_if.o_Ready !== 1'b0 || ecb_if.o_Valid !== 1'b1) ok = 1'b0;
    end
    chk("bp_hold", ok, 128'd1);
    recv(1'b0, "ecb_keyaccept", lat);
    send(1'b0, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
    recv(1'b0, "ecb_key_kept", lat);

    // CTR, SP 800-38A blocks 1 and 2
    ctr_key = k_nist; ctr_key_ld = 1'b1;
    ctr_ctr = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff; ctr_ctr_ld = 1'b1;
    step(1);
    ctr_key_ld = 1'b0; ctr_ctr_ld = 1'b0;
    chk("ctr_keyload_ready", ctr_if.o_Ready, 128'd1);
    send(1'b1, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h874d6191b620e3261bef6864990db6ce);
    recv(1'b1, "ctr_nist1", lat);
    send(1'b1, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h9806f66b7970fdff8617187bb9fffdff);
    recv(1'b1, "ctr_nist2", lat);

    // CTR low-32-bit wrap, loads coinciding with accept
    ctr_key = 128'd0; ctr_key_ld = 1'b1; ctr_ctr = ctr_wrap; ctr_ctr_ld = 1'b1;
    send(1'b1, 128'd0, aes_ref(128'd0, ctr_wrap));
    ctr_key_ld = 1'b0; ctr_ctr_ld = 1'b0;
    recv(1'b1, "ctr_wrap1", lat);
    send(1'b1, 128'd0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    recv(1'b1, "ctr_wrap2", lat);

    // Reset in the middle of a block
    ecb_key = k_fips; ecb_key_ld = 1'b1;
    send(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    ecb_key_ld = 1'b0;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", ecb_if.o_Valid, 128'd0);
    chk("midrst_ready", ecb_if.o_Ready, 128'd0);
    chk("midrst_busy",  ecb_if.o_Busy,  128'd0);
    chk("midrst_data",  ecb_if.o_Data,  128'd0);
    sb_q.delete();
    step(2);
    rst_n = 1'b1;
    ecb_if.i_Valid = 1'b1; ecb_if.i_Ready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (ecb_if.o_Ready !== 1'b0 || ecb_if.o_Valid !== 1'b0) ok = 1'b0;
    end
    chk("postrst_idle", ok, 128'd1);
    ecb_if.i_Valid = 1'b0; ecb_if.i_Ready = 1'b0;
    ecb_key = k_fips; ecb_key_ld = 1'b1;
    step(1);
    ecb_key_ld = 1'b0;
    chk("postrst_keyload_ready", ecb_if.o_Ready, 128'd1);
    send(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    recv(1'b0, "postrst_fips", lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
